conv_encoder_k3: RTL and testbench

Rate-1/2 feedforward convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder's add-compare-select datapath. It accepts a bit stream framed by `in_last` and emits one 2-bit code symbol per input bit. Each frame is terminated with K-1 zero tail bits, so every frame ends in the all-zero trellis state the decoder expects. The block also drives the decoder bench and serves as the TX half of the link model.

---
 rtl/conv_encoder_k3.sv | 104 ++++++++++
 tb/tb_conv_encoder_k3.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_k3.sv
// Rate-1/2 feedforward convolutional encoder, K-1 zero tail bits per frame; 1-cycle latency.
// Registered output; in_ready drops while the output is stalled and throughout the tail.
module conv_encoder_k3 #(
  parameter int             K  = 3,
  parameter logic [K-1:0]   G0 = 3'b111,
  parameter logic [K-1:0]   G1 = 3'b101
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_sym,
  output logic       out_last,
  output logic       busy
);

  localparam int CW = $clog2(K);

  typedef enum logic {DATA, TAIL} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   tail_cnt, tail_cnt_nxt;
  logic [K-2:0]    sr;
  logic [K-1:0]    w;
  logic            out_free;
  logic            load;
  logic            u;
  logic            final_tail;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= DATA;
      tail_cnt <= '0;
    end else begin
      state    <= state_nxt;
      tail_cnt <= tail_cnt_nxt;
    end
  end

  always_comb begin
    out_free     = !out_valid || out_ready;
    state_nxt    = state;
    tail_cnt_nxt = tail_cnt;
    in_ready     = 1'b0;
    load         = 1'b0;
    u            = 1'b0;
    final_tail   = 1'b0;
    case (state)
      DATA: begin
        in_ready = out_free;
        if (in_valid && out_free) begin
          load = 1'b1;
          u    = in_bit;
          if (in_last) begin
            state_nxt    = TAIL;
            tail_cnt_nxt = CW'(K - 1);
          end
        end
      end
      TAIL: begin
        // tail bits are zeros, flushing the trellis back to state 0
        if (out_free) begin
          load         = 1'b1;
          tail_cnt_nxt = tail_cnt - 1'b1;
          if (tail_cnt == CW'(1)) begin
            final_tail = 1'b1;
            state_nxt  = DATA;
          end
        end
      end
      default: state_nxt = DATA;
    endcase
    w = {u, sr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr        <= '0;
      out_valid <= 1'b0;
      out_sym   <= 2'b00;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (load) begin
        sr        <= w[K-1:1];
        out_sym   <= {^(w & G1), ^(w & G0)};
        out_last  <= final_tail;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // a new frame accepted in the same cycle as out_last keeps busy high
      if (load)
        busy <= 1'b1;
      else if (out_valid && out_ready && out_last)
        busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Bench for conv_encoder_k3: directed K=3 frames plus a random K=4 generator sweep,
// all checked against a convolution-sum reference model.
module tb_conv_encoder_k3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, in_valid, in_bit, in_last, out_ready;
  logic       a_in_ready, a_out_valid, a_out_last, a_busy;
  logic [1:0] a_out_sym;
  logic       b_in_ready, b_out_valid, b_out_last, b_busy;
  logic [1:0] b_out_sym;

  conv_encoder_k3 dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_bit(in_bit), .in_last(in_last), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_sym(a_out_sym), .out_last(a_out_last), .busy(a_busy)
  );

  conv_encoder_k3 #(.K(4), .G0(4'b1101), .G1(4'b1111)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_bit(in_bit), .in_last(in_last), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_sym(b_out_sym), .out_last(b_out_last), .busy(b_busy)
  );

  bit         sel;
  logic       cur_in_ready, cur_out_valid, cur_out_last, cur_busy;
  logic [1:0] cur_out_sym;
  assign cur_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign cur_out_valid = sel ? b_out_valid : a_out_valid;
  assign cur_out_last  = sel ? b_out_last  : a_out_last;
  assign cur_out_sym   = sel ? b_out_sym   : a_out_sym;
  assign cur_busy      = sel ? b_busy      : a_busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit         src_bit[0:511];
  bit         src_last[0:511];
  int         src_n;
  logic [1:0] got_sym[$];
  bit         got_last[$];
  int         got_cyc[$];
  int         acc_cyc[$];
  bit         rdy_at[0:8191];
  int         base_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Symbol i of a frame is a convolution of the generator taps with the
  // zero-extended input sequence; b(i) is the current bit, b(i-1) the previous.
  function automatic logic [1:0] model_sym(input int start, input int len, input int i);
    int       k  = sel ? 4 : 3;
    logic [6:0] g0 = sel ? 7'b0001101 : 7'b0000111;
    logic [6:0] g1 = sel ? 7'b0001111 : 7'b0000101;
    bit       p0 = 1'b0;
    bit       p1 = 1'b0;
    for (int t = 0; t < k; t++) begin
      int j = i - t;
      bit b = (j >= 0 && j < len) ? src_bit[start + j] : 1'b0;
      p0 ^= g0[k-1-t] & b;
      p1 ^= g1[k-1-t] & b;
    end
    return {p1, p0};
  endfunction

  task automatic clear_src();
    src_n = 0;
  endtask

  // Frame bits are given MSB first: add_frame(4'b1011, 4) sends 1,0,1,1.
  task automatic add_frame(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      src_bit[src_n]  = bits[n-1-i];
      src_last[src_n] = (i == n - 1);
      src_n++;
    end
  endtask

  // rmode: 0 = out_ready always 1, 1 = pattern 1,0,0,..., 2 = random
  task automatic run(input int rmode, input bit gaps, input int budget);
    int         idx = 0;
    int         nfr = 0;
    int         nexp;
    int         phase = 0;
    int         k = sel ? 4 : 3;
    int         start = 0;
    int         e = 0;
    bit         prev_stall = 1'b0;
    logic [3:0] prev_out = '0;
    for (int j = 0; j < src_n; j++) if (src_last[j]) nfr++;
    nexp = src_n + nfr * (k - 1);
    got_sym.delete(); got_last.delete(); got_cyc.delete(); acc_cyc.delete();
    base_cyc = cyc;
    while ((idx < src_n || got_sym.size() < nexp) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
      in_valid = (idx < src_n) && (!gaps || $urandom_range(0, 3) != 0);
      in_bit   = src_bit[idx];
      in_last  = src_last[idx];
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (phase % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      phase++;
      @(negedge clk);
      rdy_at[(cyc - base_cyc) & 8191] = cur_in_ready;
      if (prev_stall)
        check("stall_hold", 32'({cur_out_valid, cur_out_last, cur_out_sym}), 32'(prev_out));
      prev_stall = cur_out_valid && !out_ready;
      prev_out   = {cur_out_valid, cur_out_last, cur_out_sym};
      if (prev_stall) check("stall_in_ready", 32'(cur_in_ready), 0);
      if (cur_out_valid && out_ready) begin
        got_sym.push_back(cur_out_sym);
        got_last.push_back(cur_out_last);
        got_cyc.push_back(cyc);
        if (sel && cur_out_last) check("sweep_sr_zero", 32'(dut_b.sr), 0);
      end
      if (in_valid && cur_in_ready) begin
        acc_cyc.push_back(cyc);
        idx++;
      end
    end
    if (budget == 0) check("timeout_symbols", 32'(got_sym.size()), 32'(nexp));
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_out_valid", 32'(cur_out_valid), 0);
    check("idle_busy", 32'(cur_busy), 0);
    check("symbol_count", 32'(got_sym.size()), 32'(nexp));
    for (int j = 0; j < src_n; j++) begin
      if (src_last[j]) begin
        int len = j - start + 1;
        for (int i = 0; i < len + k - 1; i++) begin
          if (e < got_sym.size()) begin
            check("sym", 32'(got_sym[e]), 32'(model_sym(start, len, i)));
            check("last", 32'(got_last[e]), 32'(i == len + k - 2));
          end
          e++;
        end
        start = j + 1;
      end
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] basic_exp;
    int          a0;
    sel = 1'b0;
    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(a_out_valid), 0);
    check("rst_out_sym", 32'(a_out_sym), 0);
    check("rst_out_last", 32'(a_out_last), 0);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_in_ready", 32'(a_in_ready), 1);
    check("rst_b_out_valid", 32'(b_out_valid), 0);
    check("rst_b_in_ready", 32'(b_in_ready), 1);

    // basic frame 1,0,1,1
    clear_src(); add_frame(32'b1011, 4);
    run(0, 1'b0, 200);
    basic_exp = 12'b11_01_00_10_10_11;
    for (int i = 0; i < 6; i++)
      if (i < got_sym.size()) check("basic_const", 32'(got_sym[i]), 32'(basic_exp[11-2*i -: 2]));
    if (got_cyc.size() == 6 && acc_cyc.size() == 4) begin
      check("basic_latency", 32'(got_cyc[0] - acc_cyc[0]), 1);
      check("basic_no_bubble", 32'(got_cyc[5] - got_cyc[0]), 5);
    end else check("basic_counts", 32'(got_cyc.size()), 6);

    // single-bit frame
    clear_src(); add_frame(32'b1, 1);
    run(0, 1'b0, 100);
    if (acc_cyc.size() == 1) begin
      a0 = acc_cyc[0] - base_cyc;
      check("single_tail_rdy1", 32'(rdy_at[(a0 + 1) & 8191]), 0);
      check("single_tail_rdy2", 32'(rdy_at[(a0 + 2) & 8191]), 0);
      check("single_after_rdy", 32'(rdy_at[(a0 + 3) & 8191]), 1);
    end else check("single_accepts", 32'(acc_cyc.size()), 1);

    // backpressure with out_ready 1,0,0,...
    clear_src(); add_frame(32'b1011, 4);
    run(1, 1'b0, 300);

    // back-to-back frames 1,1 then 1,0
    clear_src(); add_frame(32'b11, 2); add_frame(32'b10, 2);
    run(0, 1'b0, 200);
    if (got_cyc.size() == 8 && acc_cyc.size() == 4) begin
      check("b2b_no_idle", 32'(got_cyc[7] - got_cyc[0]), 7);
      check("b2b_accept_on_last", 32'(acc_cyc[2]), 32'(got_cyc[3]));
    end else check("b2b_counts", 32'(got_cyc.size()), 8);

    // reset after the 2nd bit, colliding with a 3rd handshake
    @(posedge clk); #1 in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 in_bit = 1'b0;
    @(posedge clk); #1 in_bit = 1'b1; in_last = 1'b1; reset = 1'b1;
    @(negedge clk);
    check("rst_mid_busy_before", 32'(a_busy), 1);
    @(posedge clk); #1 reset = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", 32'(a_out_valid), 0);
    check("rst_mid_busy", 32'(a_busy), 0);
    check("rst_mid_out_last", 32'(a_out_last), 0);
    check("rst_mid_in_ready", 32'(a_in_ready), 1);
    clear_src(); add_frame(32'b1, 1);
    run(0, 1'b0, 100);

    // K=4 generator sweep with random frames, gaps and backpressure
    sel = 1'b1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    clear_src();
    for (int f = 0; f < 20; f++) add_frame($urandom, $urandom_range(1, 12));
    run(2, 1'b1, 20000);
    clear_src();
    for (int f = 0; f < 10; f++) add_frame($urandom, $urandom_range(1, 6));
    run(0, 1'b0, 5000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
